// File: rtl/delay_line_reader_xppc_pkg.sv
// Shared types and helpers for the pixel delay-line reader.
package delay_line_pkg;

  localparam int AXI_SYNC_SIGNALS  = 2;
  localparam int SAMPLE_DATA_WIDTH = 96;

  typedef struct packed {
    logic                         user;
    logic                         last;
    logic [SAMPLE_DATA_WIDTH-1:0] data;
  } sample_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/delay_line_reader_xppc_bram.sv
// Simple dual-port RAM: one write port, one registered read port (latency 1, read-first).
module sdp_bram_xppc #(
  parameter int WIDTH = 98,
  parameter int DEPTH = 960,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_line_reader_xppc.sv
// Ring-buffered bridge from the ce-driven pixel pipeline to an AXI4-Stream master.
module delay_line_reader_xppc
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int DEPTH        = 960,
  parameter int AFULL_MARGIN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_ce,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_last,
  input  logic                         s_user,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         full,
  output logic                         almost_full,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW       = ptr_w(DEPTH);
  localparam int LW       = $clog2(DEPTH + 1);
  localparam int WW       = DATA_WIDTH + AXI_SYNC_SIGNALS;
  localparam int AF_LEVEL = DEPTH - AFULL_MARGIN;

  localparam logic [PW-1:0] LAST_ADDR = PW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L      = (AF_LEVEL <= 0) ? '0 : LW'(AF_LEVEL);

  typedef struct packed {
    logic                  user;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] mem_count, level_q;
  logic          in_flight, overflow_q;
  logic          out_valid, skid_valid;
  word_t         out_word, skid_word, ram_word;
  logic [WW-1:0] ram_rdata;
  logic          wr_en, hs, rd_issue;
  logic [1:0]    free_slots;

  assign wr_en    = s_ce && !full;
  assign hs       = out_valid && m_axis_tready;
  assign ram_word = word_t'(ram_rdata);

  // Slots being vacated by this cycle's handshake count as free so a steady stream has no bubbles.
  always_comb begin
    free_slots = 2'd2 - {1'b0, out_valid} - {1'b0, skid_valid} + {1'b0, hs};
    rd_issue   = (mem_count != '0) && (free_slots > {1'b0, in_flight});
  end

  sdp_bram_xppc #(
    .WIDTH (WW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({s_user, s_last, s_data}),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      level_q    <= '0;
      in_flight  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + PW'(1);
      if (rd_issue) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + PW'(1);
      case ({wr_en, rd_issue})
        2'b10:   mem_count <= mem_count + LW'(1);
        2'b01:   mem_count <= mem_count - LW'(1);
        default: mem_count <= mem_count;
      endcase
      case ({wr_en, hs})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      in_flight  <= rd_issue;
      overflow_q <= overflow_q | (s_ce & full);
    end
  end

  // Issue control guarantees returning data never meets a full output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_word   <= '0;
      skid_word  <= '0;
    end else if (hs) begin
      if (skid_valid) begin
        out_word   <= skid_word;
        skid_valid <= 1'b0;
      end else if (in_flight) begin
        out_word <= ram_word;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_flight) begin
      if (!out_valid) begin
        out_word  <= ram_word;
        out_valid <= 1'b1;
      end else begin
        skid_word  <= ram_word;
        skid_valid <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_word.data;
  assign m_axis_tlast  = out_word.last;
  assign m_axis_tuser  = out_word.user;
  assign m_axis_tvalid = out_valid;
  assign full          = (level_q == DEPTH_L);
  assign almost_full   = (level_q >= AF_L);
  assign overflow      = overflow_q;
  assign level         = level_q;

endmodule

// File: tb/tb_delay_line_reader_xppc.sv
// Directed self-checking bench for delay_line_reader_xppc (DEPTH=8, AFULL_MARGIN=2).
module tb_delay_line_reader_xppc;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          s_ce, s_last, s_user;
  logic [DW-1:0] s_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready;
  logic          full, almost_full, overflow;
  logic [LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delay_line_reader_xppc #(
    .DATA_WIDTH   (DW),
    .DEPTH        (D),
    .AFULL_MARGIN (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_ce          (s_ce),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_user        (s_user),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .full          (full),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .level         (level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          wn, rn;
    logic        stall;
    logic [10:0] held;

    rst = 1'b1; s_ce = 1'b0; s_data = '0; s_last = 1'b0; s_user = 1'b0; m_axis_tready = 1'b0;
    tick(); tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Streaming: first word valid two edges after its write, then no gaps.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_ce   = (i < 6);
      s_data = DW'(i);
      tick();
      if (i >= 2 && i < 8) begin
        check("stream_valid", m_axis_tvalid, 1);
        check("stream_data", m_axis_tdata, i - 2);
      end else begin
        check("stream_idle", m_axis_tvalid, 0);
      end
    end
    s_ce = 1'b0;
    check("stream_level", level, 0);

    // Backpressure fill, almost_full threshold, overflow drop.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_ce   = 1'b1;
      s_data = DW'(8'h10 + i);
      tick();
      check("bp_level", level, i + 1);
      check("bp_afull", almost_full, (i + 1) >= 6);
    end
    s_ce = 1'b0;
    check("bp_full", full, 1);
    s_ce = 1'b1; s_data = 8'hAA;
    tick();
    s_ce = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_level", level, 8);
    check("ovf_full", full, 1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", m_axis_tvalid, 1);
      check("drain_data", m_axis_tdata, 8'h10 + i);
      tick();
    end
    check("drain_empty", m_axis_tvalid, 0);
    check("drain_level", level, 0);
    check("ovf_sticky", overflow, 1);

    // Simultaneous write and handshake keeps level unchanged.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_ce = 1'b1; s_data = DW'(8'h30 + i);
      tick();
    end
    check("sim_level5", level, 5);
    check("sim_afull5", almost_full, 0);
    s_data = 8'h35; m_axis_tready = 1'b1;
    tick();
    check("sim_level_same", level, 5);
    check("sim_next_data", m_axis_tdata, 8'h31);
    m_axis_tready = 1'b0; s_data = 8'h36;
    tick();
    s_ce = 1'b0;
    check("sim_level6", level, 6);
    check("sim_afull6", almost_full, 1);
    m_axis_tready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      check("sim_drain", m_axis_tdata, 8'h30 + i);
      tick();
    end
    check("sim_level_end", level, 0);

    // Pointer wrap with sidebands under alternating tready.
    wn = 0; rn = 0; stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 100 && rn < 20; cyc++) begin
      m_axis_tready = (cyc % 2 == 0);
      if (stall) check("wrap_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
      if (wn < 20 && cyc % 2 == 0) begin
        s_ce   = 1'b1;
        s_data = DW'(8'h40 + wn);
        s_last = (wn == 9 || wn == 19);
        s_user = (wn == 0);
        wn++;
      end else begin
        s_ce = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("wrap_data", m_axis_tdata, 8'h40 + rn);
        check("wrap_last", m_axis_tlast, (rn == 9 || rn == 19));
        check("wrap_user", m_axis_tuser, (rn == 0));
        rn++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
      tick();
    end
    s_ce = 1'b0; s_last = 1'b0; s_user = 1'b0;
    check("wrap_count", rn, 20);
    check("wrap_level", level, 0);

    // Asynchronous reset mid-operation.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_ce = 1'b1; s_data = DW'(8'h50 + i);
      tick();
    end
    s_ce = 1'b0;
    check("pre_rst_level", level, 4);
    check("pre_rst_valid", m_axis_tvalid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", m_axis_tvalid, 0);
    check("arst_level", level, 0);
    check("arst_full", full, 0);
    check("arst_overflow", overflow, 0);
    tick();
    rst = 1'b0; m_axis_tready = 1'b1;
    s_ce = 1'b1; s_data = 8'h11;
    tick();
    s_ce = 1'b0;
    check("post_rst_lat0", m_axis_tvalid, 0);
    tick();
    check("post_rst_lat1", m_axis_tvalid, 0);
    tick();
    check("post_rst_valid", m_axis_tvalid, 1);
    check("post_rst_data", m_axis_tdata, 8'h11);
    tick();
    check("post_rst_empty", m_axis_tvalid, 0);
    check("post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_reader_xppc.md
Name: delay_line_reader_xppc

Overview:
- Read-side counterpart of the BRAM pixel delay line.
- Accepts samples from the ce-driven pixel pipeline, with no backpressure, into a BRAM ring buffer.
- Drains them in order onto an AXI4-Stream master with full tready backpressure.
- Sits between the stereo cost/window pipeline and the AXI output DMA. Absorbs DMA stalls and flags overflow instead of corrupting the stream.

Parameters:
- DATA_WIDTH, 96, pixel payload width in bits, excluding sync bits.
- DEPTH, 960, ring-buffer depth in samples; any value ≥ 4, need not be a power of two.
- AFULL_MARGIN, 16, almost_full asserts when free entries ≤ AFULL_MARGIN.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_ce  in  1  write strobe; one sample per cycle when high
- s_data  in  DATA_WIDTH  sample payload
- s_last  in  1  end-of-line marker
- s_user  in  1  start-of-frame marker
- m_axis_tdata  out  DATA_WIDTH  output payload
- m_axis_tlast  out  1  copy of s_last
- m_axis_tuser  out  1  copy of s_user
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- full  out  1  level == DEPTH
- almost_full  out  1  DEPTH − level ≤ AFULL_MARGIN
- overflow  out  1  sticky; a write was dropped
- level  out  $clog2(DEPTH+1)  samples held: memory + in-flight read + output stages

Behaviour:
- Reset (async assert, sync release):
  - Pointers, level, overflow, tvalid and the skid valid bit all go to 0.
  - tdata, tlast and tuser reset to 0.
  - RAM contents are not reset.
  - Reset mid-line discards all held data. The first write after reset lands at address 0.
- Write side:
  - A write occurs on a clk edge when s_ce && !full.
  - The word {s_user, s_last, s_data} is stored at wr_ptr.
  - wr_ptr wraps DEPTH−1 → 0.
  - s_ce while full drops the word, sets overflow, and leaves level unchanged.
  - full is the registered value, so a handshake in the same cycle does not rescue the dropped word.
- Read engine:
  - Uses a 1-cycle-latency BRAM read plus a 2-entry output stage: output register, then skid register.
  - A read is issued when the memory count > 0 and (output slots free − reads in flight) > 0.
  - rd_ptr wraps DEPTH−1 → 0.
  - Returning RAM data fills the output register if it is empty (or being emptied this cycle), otherwise the skid register.
  - On a handshake, the skid register moves into the output register.
- Latency: a sample written at edge k issues its read at edge k+1 and appears with tvalid=1 after edge k+2, with an idle downstream.
- Throughput: with tready held high, one sample per cycle is sustained indefinitely. No bubbles after the first word.
- AXI rules:
  - Once tvalid is high, tdata, tlast and tuser stay stable until tvalid && tready.
  - tvalid never depends combinationally on tready.
  - tready is never required for writes.
- Level arithmetic:
  - level += write accepted; level −= AXI handshake, in the same cycle (net 0 when both occur).
  - Invariant: level ≤ DEPTH.
  - Memory count and in-flight counts are tracked internally. Their sum with the output-stage occupancy equals level.
- Order: output order equals accepted write order, including sideband bits, across pointer wrap.

Decomposition:
- Package delay_line_pkg:
  - sample_t packed struct {user, last, data[DATA_WIDTH-1:0]}
  - function ptr_w(depth) returning $clog2(depth)
  - AXI_SYNC_SIGNALS = 2
- Sub-module sdp_bram_xppc:
  - Simple dual-port RAM: one write port, one read port.
  - Read latency 1, no reset on the array, block-RAM primitive, read_first.
- The reader module holds the pointers, counters, prefetch control and the 2-entry output stage.

Test Plan:
- Stream in: DEPTH=8, write 0..5 on consecutive cycles with tready=1 → tdata 0..5 in order. First tvalid 2 cycles after the first write edge. No gaps. level returns to 0.
- Backpressure: tready=0, write 8 words → full=1, level=8. Then tready=1 → 8 words out in order, one per cycle.
- Overflow: DEPTH=8 while full, write 0xAA → overflow=1, 0xAA never appears, level stays 8. overflow remains 1 after draining.
- Wrap and sidebands: write 20 words, s_last on word 9 and word 19, s_user on word 0, tready toggling 1010… → tlast only on words 9 and 19, tuser only on word 0. Data stays stable while tvalid && !tready.
- Simultaneous events: level=5, write plus handshake in the same cycle → level stays 5. AFULL_MARGIN=2 → almost_full asserts exactly at level 6.
- Reset mid-operation: assert rst while level=4 and tvalid=1 → tvalid, level, overflow and full drop immediately (async). The next write 0x11 emerges as the first word, 2 cycles later.
